// File: rtl/pdm_sample_scheduler_pkg.sv
// rtl/pdm_sample_scheduler_pkg.sv - shared state encoding and mid-scale helper for the sample scheduler
package pdm_sample_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  // Mid-scale code for a given amplitude width: 1 << (bits-1).
  function automatic int unsigned midscale(input int unsigned bits);
    return 32'd1 << (bits - 1);
  endfunction

endpackage

// File: rtl/pdm_sample_scheduler_tick_divider.sv
// rtl/pdm_sample_scheduler_tick_divider.sv - reload counter producing one tick per sample period
module pdm_sample_scheduler_tick_divider #(
  parameter int DIV_BITS = 16
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic                run_i,
  input  logic                run_next_i,
  input  logic [DIV_BITS-1:0] sample_period_i,
  output logic                sample_tick_o
);

  logic [DIV_BITS-1:0] cnt_q, cnt_d;
  logic [DIV_BITS-1:0] reload;

  // The period is sampled at the reload itself, so a change lands on the next interval.
  assign reload        = (sample_period_i == '0) ? '0 : sample_period_i - DIV_BITS'(1);
  assign sample_tick_o = run_i && (cnt_q == '0);

  // Count down while streaming; park at zero so the first tick after PRIME is immediate.
  always_comb begin
    cnt_d = '0;
    if (run_i && run_next_i) begin
      if (sample_tick_o) begin
        cnt_d = reload;
      end else begin
        cnt_d = cnt_q - DIV_BITS'(1);
      end
    end
  end

  // Counter register.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pdm_sample_scheduler.sv
// rtl/pdm_sample_scheduler.sv - buffers one upstream sample and applies it to the PDM amplitude on each tick
module pdm_sample_scheduler
  import pdm_sample_scheduler_pkg::*;
#(
  parameter int DATA_BITS = 10,
  parameter int DIV_BITS  = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [DIV_BITS-1:0]  sample_period,
  input  logic [DATA_BITS-1:0] sample_in,
  input  logic                 sample_valid,
  output logic                 sample_ready,
  output logic [DATA_BITS-1:0] amplitude,
  output logic                 sample_tick,
  output logic                 underrun
);

  localparam logic [DATA_BITS-1:0] MIDSCALE = DATA_BITS'(midscale(DATA_BITS));

  state_e               state_q, state_d;
  logic [DATA_BITS-1:0] buf_q, buf_d;
  logic                 buf_full_q, buf_full_d;
  logic [DATA_BITS-1:0] amp_q, amp_d;
  logic                 underrun_q, underrun_d;
  logic                 run, run_next, hs;

  assign run       = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign run_next  = (state_d == ST_RUN) || (state_d == ST_DRAIN);
  assign hs        = sample_valid && sample_ready;
  assign amplitude = amp_q;
  assign underrun  = underrun_q;

  pdm_sample_scheduler_tick_divider #(
    .DIV_BITS(DIV_BITS)
  ) u_div (
    .clock_i        (clock),
    .reset_i        (reset),
    .run_i          (run),
    .run_next_i     (run_next),
    .sample_period_i(sample_period),
    .sample_tick_o  (sample_tick)
  );

  // Ready depends only on registered state and the tick, never on sample_valid.
  always_comb begin
    sample_ready = 1'b0;
    case (state_q)
      ST_PRIME: sample_ready = !buf_full_q;
      ST_RUN:   sample_ready = !buf_full_q || sample_tick;
      default:  sample_ready = 1'b0;
    endcase
  end

  // Next state, buffer transfer on tick, and refill on handshake.
  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    amp_d      = amp_q;
    underrun_d = underrun_q;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d    = ST_PRIME;
          underrun_d = 1'b0;
        end
      end
      ST_PRIME: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (hs || buf_full_q) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (sample_tick) begin
          if (buf_full_q) begin
            amp_d      = buf_q;
            buf_full_d = 1'b0;
          end else begin
            underrun_d = 1'b1;
          end
        end
        if (!enable) begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        if (sample_tick) begin
          if (buf_full_q) begin
            amp_d      = buf_q;
            buf_full_d = 1'b0;
          end else if (!enable) begin
            amp_d   = MIDSCALE;
            state_d = ST_IDLE;
          end
        end
        if (enable) begin
          state_d = ST_RUN;
        end
      end
    endcase
    // A handshake refills after any same-edge transfer, so buf_full stays set.
    if (hs) begin
      buf_d      = sample_in;
      buf_full_d = 1'b1;
    end
  end

  // State and datapath registers; reset discards the buffer and parks the output.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      amp_q      <= MIDSCALE;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      amp_q      <= amp_d;
      underrun_q <= underrun_d;
    end
  end

endmodule

// File: tb/tb_pdm_sample_scheduler.sv
// tb/tb_pdm_sample_scheduler.sv - directed self-checking bench for pdm_sample_scheduler
module tb_pdm_sample_scheduler;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] sample_period;
  logic [9:0]  sample_in;
  logic        sample_valid;
  logic        sample_ready;
  logic [9:0]  amplitude;
  logic        sample_tick;
  logic        underrun;

  int n_checks = 0;
  int n_fail   = 0;
  int gen_inc  = 0;

  pdm_sample_scheduler #(
    .DATA_BITS(10),
    .DIV_BITS (16)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .sample_period(sample_period),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .amplitude    (amplitude),
    .sample_tick  (sample_tick),
    .underrun     (underrun)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // One cycle with an upstream generator that offers the next value after each handshake.
  task automatic gen_step();
    bit hs;
    hs = sample_ready && sample_valid;
    @(posedge clock);
    #1;
    if (hs) sample_in = sample_in + 10'(gen_inc);
  endtask

  int exp_amp [1:10] = '{512, 100, 100, 100, 100, 200, 200, 200, 200, 300};
  bit exp_tick[1:10] = '{1, 0, 0, 0, 1, 0, 0, 0, 1, 0};

  initial begin
    reset = 1'b1; enable = 1'b0; sample_period = 16'd4;
    sample_in = '0; sample_valid = 1'b0;

    // reset held for two cycles
    step(); step();
    check("rst_amp", amplitude, 512);
    check("rst_ready", sample_ready, 0);
    check("rst_underrun", underrun, 0);
    check("rst_tick", sample_tick, 0);
    reset = 1'b0;
    step();
    check("idle_tick", sample_tick, 0);

    // start: P=4, samples 100,200,300,... always valid
    enable = 1'b1; sample_period = 16'd4; sample_in = 10'd100; sample_valid = 1'b1; gen_inc = 100;
    gen_step();
    check("prime_ready", sample_ready, 1);
    check("prime_tick", sample_tick, 0);
    gen_step();
    for (int k = 1; k <= 10; k++) begin
      check($sformatf("start_tick_%0d", k), sample_tick, int'(exp_tick[k]));
      check($sformatf("start_amp_%0d", k), amplitude, exp_amp[k]);
      if (k < 10) gen_step();
    end
    check("start_underrun", underrun, 0);

    // reset while RUN holds a full buffer (400)
    reset = 1'b1;
    step();
    check("midrst_amp", amplitude, 512);
    check("midrst_ready", sample_ready, 0);
    check("midrst_tick", sample_tick, 0);
    reset = 1'b0; enable = 1'b0; sample_valid = 1'b0;
    step(); step();
    check("midrst_idle_amp", amplitude, 512);

    // underrun: P=3, one sample then valid drops
    enable = 1'b1; sample_period = 16'd3; sample_in = 10'd77; sample_valid = 1'b1; gen_inc = 0;
    step();
    check("ur_prime_ready", sample_ready, 1);
    step();
    sample_valid = 1'b0;
    check("ur_tick1", sample_tick, 1);
    check("ur_amp_n1", amplitude, 512);
    step();
    check("ur_amp_n2", amplitude, 77);
    check("ur_tick_n2", sample_tick, 0);
    step();
    check("ur_before", underrun, 0);
    step();
    check("ur_tick2", sample_tick, 1);
    step();
    check("ur_set", underrun, 1);
    check("ur_amp_hold", amplitude, 77);
    enable = 1'b0;
    step();
    check("ur_drain_sticky", underrun, 1);
    step();
    check("ur_drain_tick", sample_tick, 1);
    step();
    check("ur_idle_amp", amplitude, 512);
    check("ur_idle_sticky", underrun, 1);
    check("ur_idle_ready", sample_ready, 0);
    enable = 1'b1;
    step();
    check("ur_cleared", underrun, 0);
    check("ur_prime2_ready", sample_ready, 1);

    // drain: buffered 700 goes out, then mid-scale and IDLE
    sample_period = 16'd4; sample_in = 10'd600; sample_valid = 1'b1; gen_inc = 100;
    gen_step();
    check("dr_tick_n1", sample_tick, 1);
    gen_step();
    check("dr_amp_n2", amplitude, 600);
    check("dr_ready_n2", sample_ready, 0);
    enable = 1'b0;
    gen_step();
    check("dr_ready_n3", sample_ready, 0);
    check("dr_tick_n3", sample_tick, 0);
    gen_step(); gen_step();
    check("dr_tick_n5", sample_tick, 1);
    check("dr_amp_n5", amplitude, 600);
    gen_step();
    check("dr_amp_n6", amplitude, 700);
    gen_step(); gen_step(); gen_step();
    check("dr_tick_n9", sample_tick, 1);
    check("dr_amp_n9", amplitude, 700);
    gen_step();
    check("dr_amp_park", amplitude, 512);
    check("dr_ready_idle", sample_ready, 0);
    check("dr_underrun", underrun, 0);
    check("dr_tick_idle", sample_tick, 0);

    // period 0 gives a tick every cycle, then 5 -> 2 mid-period
    enable = 1'b1; sample_period = 16'd0; sample_in = 10'd10; gen_inc = 1;
    gen_step();
    gen_step();
    check("p0_tick_n1", sample_tick, 1);
    gen_step();
    check("p0_tick_n2", sample_tick, 1);
    check("p0_amp_n2", amplitude, 10);
    gen_step();
    check("p0_tick_n3", sample_tick, 1);
    check("p0_amp_n3", amplitude, 11);
    sample_period = 16'd5;
    gen_step();
    check("pc_tick_n4", sample_tick, 0);
    check("pc_amp_n4", amplitude, 12);
    sample_period = 16'd2;
    for (int k = 5; k <= 12; k++) begin
      gen_step();
      check($sformatf("pc_tick_n%0d", k), sample_tick, (k == 8 || k == 10 || k == 12) ? 1 : 0);
    end
    check("pc_amp_n12", amplitude, 14);
    check("pc_underrun", underrun, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
